// File: rtl/dispense_scheduler_if.sv
// Bundle of panel-side request lines and scheduler-side service outputs.
// With DISPENSE_STATS_EN defined, the bundle also carries the vend_count statistic.
interface dispense_scheduler_if;
   logic [3:0] req;
   logic [7:0] req_change;
   logic [3:0] grant;
   logic       motor_on;
   logic       coin_out;
   logic [3:0] done;
   logic       busy;
`ifdef DISPENSE_STATS_EN
   logic [7:0] vend_count;

   modport master (output req, req_change,
                   input  grant, motor_on, coin_out, done, busy, vend_count);
   modport slave  (input  req, req_change,
                   output grant, motor_on, coin_out, done, busy, vend_count);
`else
   modport master (output req, req_change,
                   input  grant, motor_on, coin_out, done, busy);
   modport slave  (input  req, req_change,
                   output grant, motor_on, coin_out, done, busy);
`endif
endinterface

// File: rtl/dispense_scheduler.sv
// Round-robin scheduler sharing one dispense motor and coin-return unit among four panels.
// Optional feature macro DISPENSE_STATS_EN adds a saturating 8-bit vend counter.
module dispense_scheduler #(
   parameter int MOTOR_CYCLES = 8,
   parameter int N_REQ        = 4
) (
   input  logic clk,
   input  logic reset,
   dispense_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE, DONE} state_t;

   localparam logic [7:0] TIMER_LOAD = 8'(MOTOR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic       motor_q, motor_d;
   logic       coin_q, coin_d;
   logic [3:0] done_q, done_d;
   logic [7:0] timer_q, timer_d;
   logic [1:0] coins_q, coins_d;
   logic [1:0] last_q, last_d;
   logic [1:0] cur_q, cur_d;

   logic [1:0] winner;
   logic [1:0] cand;
   logic       found;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      winner = last_q + 2'd1;
      cand   = last_q;
      found  = 1'b0;
      // Search starts just past the most recently served panel.
      for (int k = 1; k <= N_REQ; k++) begin
         cand = last_q + 2'(k);
         if (!found && bus.req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      motor_d = motor_q;
      coin_d  = coin_q;
      done_d  = '0;
      timer_d = timer_q;
      coins_d = coins_q;
      last_d  = last_q;
      cur_d   = cur_q;

      case (state_q)
         IDLE: begin
            grant_d = '0;
            motor_d = 1'b0;
            coin_d  = 1'b0;
            if (found) begin
               grant_d = 4'b0001 << winner;
               motor_d = 1'b1;
               coins_d = bus.req_change[{winner, 1'b0} +: 2];
               timer_d = TIMER_LOAD;
               cur_d   = winner;
               state_d = VEND;
            end
         end
         VEND: begin
            if (timer_q == 8'd0) begin
               motor_d = 1'b0;
               if (coins_q != 2'd0) begin
                  coin_d  = 1'b1;
                  state_d = CHANGE;
               end else begin
                  done_d  = grant_q;
                  state_d = DONE;
               end
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         CHANGE: begin
            // A high cycle spends a coin; the following low cycle decides whether more remain.
            if (coin_q) begin
               coin_d  = 1'b0;
               coins_d = coins_q - 2'd1;
            end else if (coins_q == 2'd0) begin
               done_d  = grant_q;
               state_d = DONE;
            end else begin
               coin_d = 1'b1;
            end
         end
         DONE: begin
            grant_d = '0;
            last_d  = cur_q;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            motor_d = 1'b0;
            coin_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         motor_q <= 1'b0;
         coin_q  <= 1'b0;
         done_q  <= '0;
         timer_q <= '0;
         coins_q <= '0;
         last_q  <= 2'd3;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         motor_q <= motor_d;
         coin_q  <= coin_d;
         done_q  <= done_d;
         timer_q <= timer_d;
         coins_q <= coins_d;
         last_q  <= last_d;
         cur_q   <= cur_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.motor_on = motor_q;
   assign bus.coin_out = coin_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != IDLE);

`ifdef DISPENSE_STATS_EN
   logic [7:0] vend_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vend_q <= '0;
      end else if (state_q == DONE && vend_q != 8'hFF) begin
         vend_q <= vend_q + 8'd1;
      end
   end

   assign bus.vend_count = vend_q;
`endif

endmodule

// File: tb/tb_dispense_scheduler.sv
// Scoreboard bench for dispense_scheduler: a driver predicts each service from the request
// rules and queues it; a monitor checks every output cycle against the queued service.
module tb_dispense_scheduler;

   localparam int MC = 8;

   typedef struct {
      logic [3:0] grant;
      int         coins;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   dispense_scheduler_if bus ();

   dispense_scheduler #(.MOTOR_CYCLES(MC), .N_REQ(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   model_last  = 3;
   int   pushes      = 0;
   bit   mon_active  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference: a panel wins if it is the first requester after the last one served.
   task automatic predict(input logic [3:0] r, input logic [7:0] c);
      int   w;
      exp_t e;
      w = 0;
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (model_last + k) % 4;
         if (r[i]) begin
            w = i;
            break;
         end
      end
      e.grant = 4'(1 << w);
      e.coins = int'(c[2*w +: 2]);
      exp_q.push_back(e);
      model_last = w;
      pushes++;
   endtask

   task automatic drive_cycle(input logic [3:0] r, input logic [7:0] c);
      bit idle;
      @(negedge clk);
      idle           = !bus.busy;
      bus.req        = r;
      bus.req_change = c;
      if (idle && r != 4'd0) predict(r, c);
   endtask

   // Reset is raised just after a falling edge so the monitor never races it.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check("reset_grant",    32'(bus.grant),    32'd0);
      check("reset_motor_on", 32'(bus.motor_on), 32'd0);
      check("reset_coin_out", 32'(bus.coin_out), 32'd0);
      check("reset_done",     32'(bus.done),     32'd0);
      check("reset_busy",     32'(bus.busy),     32'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      model_last = 3;
   endtask

   exp_t       cur;
   int         pos;
   int         len;
   logic       em;
   logic       ec;
   logic [3:0] ed;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         mon_active = 1'b0;
      end else begin
         if (!mon_active && bus.grant != 4'd0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", 32'(bus.grant), 32'd0);
            end else begin
               cur        = exp_q.pop_front();
               mon_active = 1'b1;
               pos        = 0;
            end
         end
         if (mon_active) begin
            len = MC + 2 * cur.coins + 1;
            em  = (pos < MC);
            ec  = (pos >= MC) && (pos < MC + 2 * cur.coins) && (((pos - MC) % 2) == 0);
            ed  = (pos == len - 1) ? cur.grant : 4'd0;
            check("service_cycle",
                  32'({bus.grant, bus.motor_on, bus.coin_out, bus.done, bus.busy}),
                  32'({cur.grant, em, ec, ed, 1'b1}));
            pos++;
            if (pos == len) mon_active = 1'b0;
         end else begin
            check("idle_cycle",
                  32'({bus.grant, bus.motor_on, bus.coin_out, bus.done, bus.busy}),
                  32'd0);
         end
      end
   end

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || mon_active) && t < 200) begin
         drive_cycle(4'd0, 8'd0);
         t++;
      end
      check(name, 32'(exp_q.size() == 0 && !mon_active), 32'd1);
   endtask

   initial begin
      logic [3:0] r;
      bus.req        = '0;
      bus.req_change = '0;
      do_reset();

      // Single vend, no change.
      drive_cycle(4'b0001, 8'h00);
      repeat (12) drive_cycle(4'd0, 8'h00);

      // Three change coins for panel 2.
      drive_cycle(4'b0100, 8'h30);
      repeat (16) drive_cycle(4'd0, 8'h30);

      // Every panel requesting continuously: strict rotation.
      repeat (52) drive_cycle(4'b1111, 8'h00);
      drain("drain_round_robin");

      // Request dropped and change altered right after the grant edge.
      drive_cycle(4'b0010, 8'b0000_1000);
      drive_cycle(4'b0000, 8'hFF);
      repeat (16) drive_cycle(4'd0, 8'(($urandom)));

      // Reset during the fourth motor cycle, then panel 0 must win first.
      drive_cycle(4'b0001, 8'h00);
      repeat (4) drive_cycle(4'd0, 8'h00);
      do_reset();
      drive_cycle(4'b1111, 8'h00);
      repeat (12) drive_cycle(4'd0, 8'h00);

      // Random traffic with requests and change counts moving during service.
      r = 4'd0;
      repeat (800) begin
         if ($urandom_range(3) == 0) r = 4'($urandom);
         drive_cycle(r, 8'($urandom));
      end
      drain("drain_random");

`ifdef DISPENSE_STATS_EN
      do_reset();
      pushes = 0;
      while (pushes < 260) drive_cycle(4'b0001, 8'h00);
      drain("drain_stats");
      check("vend_count_sat", 32'(bus.vend_count), 32'd255);
      drive_cycle(4'b0001, 8'h00);
      drain("drain_stats_hold");
      check("vend_count_hold", 32'(bus.vend_count), 32'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dispense_scheduler.md
DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 8, giving the motor-on duration per vend in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter N_REQ, fixed at 4, giving the number of vending front panels sharing one dispense motor and coin-return unit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: bit i high means panel i requests one vend.
REQ-006 SHALL have port req_change, input, 8 bits: bits [2i+1:2i] give the change coins (0..3) owed to panel i, sampled at grant.
REQ-007 SHALL have port grant, output, 4 bits: one-hot, marking the panel currently being served; all zero when idle.
REQ-008 SHALL have port motor_on, output, 1 bit: drives the shared dispense motor.
REQ-009 SHALL have port coin_out, output, 1 bit: each high cycle ejects one change coin.
REQ-010 SHALL have port done, output, 4 bits: one-cycle pulse on bit i when service of panel i completes.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, VEND, CHANGE and DONE; any other encoding SHALL return to IDLE on the next edge.
REQ-013 In IDLE with req != 0: select a winner round-robin, searching from (last + 1) mod 4 upward, where last is the most recently served panel.
REQ-014 On the same IDLE edge: set grant to onehot(winner), set motor_on to 1, latch req_change[winner] into coins_left, load timer with MOTOR_CYCLES-1, and go to VEND.
REQ-015 In IDLE with req == 0: hold all outputs at zero.
REQ-016 VEND: motor_on SHALL stay high for exactly MOTOR_CYCLES cycles.
REQ-017 VEND: the timer decrements each cycle; at timer == 0, set motor_on to 0 and go to CHANGE if coins_left > 0, else to DONE.
REQ-018 CHANGE: each coin SHALL be one coin_out-high cycle followed by one low cycle.
REQ-019 CHANGE: coins_left decrements on each high cycle; after the low cycle of the last coin, go to DONE.
REQ-020 DONE: pulse done[winner] for one cycle, clear grant, set last to winner, and return to IDLE.
REQ-021 A req deasserted during service SHALL be ignored; service completes.
REQ-022 A req still high in IDLE after its done pulse SHALL be treated as a new request and arbitrated normally.
REQ-023 Changes to req or req_change after the grant edge SHALL NOT affect the current service.
REQ-024 grant SHALL stay stable and one-hot from the grant edge through the DONE cycle inclusive.

Reset
REQ-025 Reset SHALL force state IDLE, grant = 0, motor_on = 0, coin_out = 0, done = 0, timer = 0, coins_left = 0, and last = 3, so panel 0 is first priority.
REQ-026 Reset asserted mid-service SHALL abort immediately, with no done pulse and the motor off.

Configuration
REQ-027 Macro DISPENSE_STATS_EN: when defined, add output vend_count, 8 bits, reset to 0, incremented on each DONE cycle and saturating at 255.
REQ-028 When DISPENSE_STATS_EN is undefined, the vend_count port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-029 Single request: req = 0001, req_change = 0 -> grant = 0001, motor_on high for 8 cycles, no coin_out, done = 0001 one cycle, busy low afterwards.
REQ-030 Change return: req = 0100, req_change[5:4] = 3 -> 8 motor cycles, then coin_out pattern 1,0,1,0,1,0, then done = 0100.
REQ-031 Round-robin: req = 1111 held constant -> grant order 0001, 0010, 0100, 1000, 0001; no panel served twice before all others.
REQ-032 Late change: req_change altered and req dropped after the grant edge -> original latched coin count ejected and done still pulses.
REQ-033 Reset mid-VEND: reset asserted during cycle 4 of the motor -> motor_on, grant and busy go to 0 immediately; no done pulse; next request to panel 0 wins first.
REQ-034 With DISPENSE_STATS_EN defined: 260 back-to-back vends -> vend_count reads 255 and holds.
